// File: rtl/tmds_decoder.sv
// TMDS channel receiver: finds the symbol boundary by hunting for control-token runs, then decodes
// aligned symbols to pixel data / control / data-enable. Define TMDS_DECODER_LOSS_CNT_EN to add o_loss_cnt.
module tmds_decoder #(
  parameter int unsigned ALIGN_TOKENS = 16,
  parameter int unsigned SEARCH_LEN   = 2048,
  parameter int unsigned MAX_ACTIVE   = 4096
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [9:0]  i_raw,
  input  logic        i_raw_valid,
  output logic        o_valid,
  output logic [7:0]  o_vd,
  output logic [1:0]  o_cd,
  output logic        o_vde,
  output logic        o_locked,
`ifdef TMDS_DECODER_LOSS_CNT_EN
  output logic [15:0] o_loss_cnt,
`endif
  output logic [3:0]  o_offset
);

  localparam int unsigned RUN_W  = $clog2(ALIGN_TOKENS + 1);
  localparam int unsigned SRCH_W = $clog2(SEARCH_LEN + 1);
  localparam int unsigned ACT_W  = $clog2(MAX_ACTIVE + 1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [9:0]        prev_q, prev_d;
  logic [3:0]        off_q, off_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [SRCH_W-1:0] search_q, search_d;
  logic [ACT_W-1:0]  act_q, act_d;
  logic              valid_d, vde_d;
  logic [7:0]        vd_d;
  logic [1:0]        cd_d;

  logic [19:0] concat;
  logic [9:0]  win;
  logic [7:0]  d_word, vd_dec;
  logic        is_tok;
  logic [1:0]  tok_cd;
  logic        lock_hit, search_hit, loss_hit;

  assign concat = {i_raw, prev_q};
  assign win    = 10'(concat >> off_q);

  // Control-token match
  always_comb begin
    is_tok = 1'b1;
    tok_cd = 2'b00;
    case (win)
      10'h354: tok_cd = 2'b00;
      10'h0AB: tok_cd = 2'b01;
      10'h154: tok_cd = 2'b10;
      10'h2AB: tok_cd = 2'b11;
      default: is_tok = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain
  always_comb begin
    d_word    = win[9] ? ~win[7:0] : win[7:0];
    vd_dec    = '0;
    vd_dec[0] = d_word[0];
    for (int i = 1; i < 8; i++) begin
      vd_dec[i] = win[8] ? (d_word[i] ^ d_word[i-1]) : ~(d_word[i] ^ d_word[i-1]);
    end
  end

  assign lock_hit   = is_tok && (run_q == RUN_W'(ALIGN_TOKENS - 1));
  assign search_hit = (search_q == SRCH_W'(SEARCH_LEN - 1));
  assign loss_hit   = !is_tok && (act_q == ACT_W'(MAX_ACTIVE - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rstn) state_q <= HUNT;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (i_raw_valid && lock_hit) state_d = LOCKED;
      LOCKED:  if (i_raw_valid && loss_hit) state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  // Next values for counters and registered outputs; lock beats precede offset steps
  always_comb begin
    prev_d   = prev_q;
    off_d    = off_q;
    run_d    = run_q;
    search_d = search_q;
    act_d    = act_q;
    valid_d  = 1'b0;
    vd_d     = o_vd;
    cd_d     = o_cd;
    vde_d    = o_vde;
    if (i_raw_valid) begin
      prev_d = i_raw;
      case (state_q)
        HUNT: begin
          vde_d = 1'b0;
          if (lock_hit) begin
            run_d    = '0;
            search_d = '0;
            act_d    = '0;
          end else if (search_hit) begin
            run_d    = '0;
            search_d = '0;
            off_d    = (off_q == 4'd9) ? 4'd0 : off_q + 4'd1;
          end else begin
            run_d    = is_tok ? run_q + 1'b1 : '0;
            search_d = search_q + 1'b1;
          end
        end
        LOCKED: begin
          if (is_tok) begin
            act_d   = '0;
            valid_d = 1'b1;
            vde_d   = 1'b0;
            cd_d    = tok_cd;
          end else if (loss_hit) begin
            act_d    = '0;
            run_d    = '0;
            search_d = '0;
            vde_d    = 1'b0;
          end else begin
            act_d   = act_q + 1'b1;
            valid_d = 1'b1;
            vde_d   = 1'b1;
            vd_d    = vd_dec;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      prev_q   <= '0;
      off_q    <= '0;
      run_q    <= '0;
      search_q <= '0;
      act_q    <= '0;
      o_valid  <= 1'b0;
      o_vd     <= '0;
      o_cd     <= '0;
      o_vde    <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      off_q    <= off_d;
      run_q    <= run_d;
      search_q <= search_d;
      act_q    <= act_d;
      o_valid  <= valid_d;
      o_vd     <= vd_d;
      o_cd     <= cd_d;
      o_vde    <= vde_d;
    end
  end

  assign o_locked = (state_q == LOCKED);
  assign o_offset = off_q;

`ifdef TMDS_DECODER_LOSS_CNT_EN
  // Saturating count of lock losses
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_loss_cnt <= '0;
    end else if (i_raw_valid && state_q == LOCKED && loss_hit && o_loss_cnt != 16'hFFFF) begin
      o_loss_cnt <= o_loss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/tmds_decoder.md
# tmds_decoder

TMDS channel receiver and decoder: the counterpart to the per-channel TMDS encoder on the HDMI output path. It takes raw 10-bit words from a deserializer whose bit alignment is arbitrary and finds the symbol boundary by hunting for control-token runs. It then decodes each aligned symbol back into 8-bit pixel data, 2-bit control, and data-enable in the pixel-clock domain. One instance serves one TMDS channel; a future HDMI capture path instantiates three.

## Interface
Parameters:
- ALIGN_TOKENS, default 16: consecutive control tokens required at one offset to declare lock.
- SEARCH_LEN, default 2048: valid beats spent at one offset before advancing the offset.
- MAX_ACTIVE, default 4096: consecutive non-token beats while locked that force loss of lock.

Ports:
- i_clk  in  1: pixel clock (25 MHz for 640x480); the only clock.
- i_rstn  in  1: reset, synchronous, active-low.
- i_raw  in  10: raw deserialized word; bit 0 was received first; rotation is arbitrary.
- i_raw_valid  in  1: i_raw is valid this cycle.
- o_valid  out  1: o_vd, o_cd and o_vde are updated this cycle (locked only).
- o_vd  out  8: decoded pixel data.
- o_cd  out  2: decoded control bits {c1,c0}; held through active video.
- o_vde  out  1: 1 when the symbol was a data word, 0 when it was a control token.
- o_locked  out  1: alignment achieved.
- o_offset  out  4: current bit offset, 0..9.

## Operation
- **Window.** A register prev holds the previous valid i_raw. The concatenation {i_raw, prev} is 20 bits. The aligned word is w = concat[offset+9 : offset]. prev and all counters advance only on i_raw_valid.
- **Control tokens:**
  - 0x354 -> cd 00
  - 0x0AB -> cd 01
  - 0x154 -> cd 10
  - 0x2AB -> cd 11
  - Any other w is data.
- **Data decode:**
  - d = w[9] ? ~w[7:0] : w[7:0]
  - vd[0] = d[0]
  - vd[i] = d[i] ^ d[i-1] when w[8] = 1; otherwise ~(d[i] ^ d[i-1]), for i = 1..7.
- **FSM states:** HUNT and LOCKED.
  - **HUNT:** run_cnt counts consecutive tokens at the current offset and clears on any data word. search_cnt counts valid beats at the offset.
    - run_cnt reaching ALIGN_TOKENS -> LOCKED.
    - Otherwise, search_cnt reaching SEARCH_LEN -> offset = offset + 1, wrapping 9 -> 0; both counters clear.
    - If the same beat satisfies both, lock wins and the offset is unchanged.
  - **LOCKED:** act_cnt counts consecutive data words and clears on any token.
    - act_cnt reaching MAX_ACTIVE -> HUNT, offset kept, all counters cleared.
- **Outputs while locked:**
  - Token: o_vde = 0, o_cd = token value, o_vd unchanged.
  - Data: o_vde = 1, o_vd = decoded value, o_cd unchanged.
- **Outputs in HUNT:** o_valid = 0, o_vde = 0; o_vd and o_cd hold their values.
- **Reset values:** all outputs 0, state HUNT, offset 0, prev 0, all counters 0.

## Timing
- All outputs are registered.
- The decode of the window completed by valid beat n appears with o_valid = 1 in the cycle after beat n.
- Lock: o_locked rises the cycle after the beat that brings run_cnt to ALIGN_TOKENS. The first o_valid belongs to the next valid beat.
- Loss: o_locked falls the cycle after the beat that brings act_cnt to MAX_ACTIVE. That beat produces no o_valid.
- Gaps in i_raw_valid: o_valid = 0 and nothing advances.
- Reset asserted mid-hunt or mid-lock: the next cycle shows reset values; there is no partial state.
- Worst-case acquisition: 10 × SEARCH_LEN valid beats.

## Configuration
- TMDS_DECODER_LOSS_CNT_EN defined: adds port o_loss_cnt (out, 16 bits).
  - Counts LOCKED -> HUNT transitions.
  - Saturates at 0xFFFF.
  - Cleared only by reset.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

## Test plan
- **Reset:** hold i_rstn = 0 for 2 cycles with random i_raw -> all outputs 0, o_offset = 0, o_locked = 0.
- **Aligned lock:** 16 beats of 0x354 at offset 0, then the encoding of 0x5A -> o_locked rises after the 16th token. The next beat gives o_valid = 1, o_vde = 1, o_vd = 0x5A, o_cd = 00.
- **Rotated stream:** stream delayed by 3 bits, blanking bursts every 800 beats -> o_offset steps 0, 1, 2, 3 at SEARCH_LEN intervals, then locks at 3 with correct data.
- **Token decode:** while locked, send 0x0AB, 0x154, 0x2AB, then one data word -> o_cd = 01, 10, 11 with o_vde = 0. The data beat gives o_vde = 1 and o_cd holds 11.
- **Loss:** while locked, send MAX_ACTIVE consecutive data words -> o_locked = 0 the cycle after the last one; o_offset unchanged; o_loss_cnt = 1 with the macro defined.
- **Reset mid-hunt:** at offset 5 with run_cnt = 10, pulse i_rstn low for one cycle -> o_offset = 0, and a fresh run of 16 tokens is required to lock.
